hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

- Pipeline hazard controller that drives the hold and flush inputs of the IF/ID, ID/EX and EX/MEM pipe registers and the PC write enable.
- Detects three conditions:
  - load-use hazards between the ID and EX stages;
  - taken branches resolved in MEM;
  - multi-cycle multiply occupancy of EX.
- Hold/flush outputs are Mealy: they depend on the current state and current inputs, so the pipe registers act on them at the same clock edge.
- Keeps a saturating stall-cycle counter for performance measurement.

## Interface
Parameters:
- MUL_LAT, 4: total cycles a multiply occupies EX; legal range 2..255.
- CNT_W, 16: width of the stall counter.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- if_id_rs_i  in  5  rs field of the instruction in IF/ID.
- if_id_rt_i  in  5  rt field of the instruction in IF/ID.
- if_id_uses_rt_i  in  1  the IF/ID instruction reads rt as a source.
- id_ex_memread_i  in  1  the ID/EX instruction is a load.
- id_ex_rt_i  in  5  destination rt of the ID/EX instruction.
- mul_start_i  in  1  the ID/EX instruction is a multiply.
- branch_taken_i  in  1  EX/MEM holds a taken branch (target valid this cycle).
- pc_hold_o  out  1  1 = PC keeps its value.
- IF_Write  out  1  1 = IF/ID holds its contents (stall).
- IF_flush  out  1  1 = IF/ID is zeroed.
- id_ex_hold_o  out  1  1 = ID/EX holds its contents.
- ID_flush  out  1  1 = ID/EX loads a bubble (all control zero).
- EX_flush  out  1  1 = EX/MEM loads a bubble.
- mul_done_o  out  1  pulse: the multiply leaves EX at this edge.
- stall_cnt_o  out  CNT_W  number of cycles with IF_Write=1.

## Operation
- States:
  - RUN;
  - MUL, with an 8-bit down-counter `cnt`.
- Condition evaluation in RUN, highest priority first:
  1. branch_taken_i=1:
     - IF_flush=1, ID_flush=1, EX_flush=1, pc_hold_o=0 (the PC takes the branch target).
     - Stay in RUN; mul_start_i and load-use are ignored (those instructions are younger and are squashed).
  2. mul_start_i=1:
     - pc_hold_o=1, IF_Write=1, id_ex_hold_o=1, EX_flush=1.
     - cnt <= MUL_LAT-2; go to MUL.
  3. Load-use:
     - Condition: id_ex_memread_i=1, id_ex_rt_i!=0, and either id_ex_rt_i==if_id_rs_i, or (if_id_uses_rt_i=1 and id_ex_rt_i==if_id_rt_i).
     - Action: pc_hold_o=1, IF_Write=1, ID_flush=1 for exactly this cycle; stay in RUN.
  4. Otherwise: all hold/flush outputs are 0.
- MUL state, cnt!=0:
  - Same outputs as the RUN multiply entry (pc_hold_o, IF_Write, id_ex_hold_o, EX_flush = 1).
  - cnt <= cnt-1.
- MUL state, cnt==0 (release cycle):
  - All hold/flush outputs are 0; mul_done_o=1; go to RUN.
- In MUL, all other inputs are don't-care and ignored:
  - mul_start_i stays high because ID/EX is held;
  - branch_taken_i cannot legally occur, since EX/MEM holds bubbles.
- Stall count: the multiply produces exactly MUL_LAT-1 stalled cycles; the multiply instruction spends MUL_LAT cycles in EX.
- Back-to-back multiplies: a multiply entering ID/EX on the release edge is detected in RUN on the next cycle.
- Stall counter: stall_cnt_o increments on each edge where IF_Write=1; it saturates at all-ones and does not wrap.

## Timing
- Reset behaviour:
  - While rst_i=1, every hold/flush output and mul_done_o is 0, regardless of the other inputs.
  - At the edge: state <= RUN, cnt <= 0, stall_cnt_o <= 0.
- Reset mid-MUL: the multiply is abandoned and outputs are 0 from the reset cycle on. After reset deasserts, a still-asserted mul_start_i starts a fresh MUL_LAT sequence.
- All hold/flush outputs are combinational from (state, cnt, inputs): zero latency relative to the pipe-register edge they control.
- mul_done_o is a one-cycle pulse, concurrent with the release cycle.
- stall_cnt_o is registered: it reflects stalls up to the previous edge.
- Invariants:
  - IF_Write and IF_flush are never both 1.
  - id_ex_hold_o and ID_flush are never both 1.
  - pc_hold_o == IF_Write at all times.
- MUL_LAT=2: the RUN entry cycle stalls, the next cycle is release (cnt loads 0).

## Test plan
- Load-use: ID/EX load to r5, IF/ID rs=5 → one cycle with pc_hold_o=IF_Write=ID_flush=1, then all 0; stall_cnt_o 0→1. Repeat with rt=0 → no stall.
- Multiply, MUL_LAT=4: mul_start_i held high → stall outputs high for exactly 3 cycles; mul_done_o on the 4th; stall_cnt_o=3. Two back-to-back multiplies → 6 stalls and 2 done pulses.
- Branch priority: branch_taken_i=1 together with mul_start_i=1 and a load-use match → IF_flush=ID_flush=EX_flush=1, pc_hold_o=0, state remains RUN, no stall counted.
- Reset mid-MUL: rst_i for 1 cycle at stall cycle 2 → outputs 0 that cycle, stall_cnt_o=0; with mul_start_i still high after reset, a full 3-cycle stall restarts.
- Saturation: CNT_W=4, apply 20 load-use stalls → stall_cnt_o stops at 15.
- MUL_LAT=2: one stall cycle, then mul_done_o=1; stall_cnt_o=1.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller.
// Drives hold/flush controls for IF/ID, ID/EX, EX/MEM and the PC write
// enable from load-use, taken-branch and multi-cycle multiply conditions.
// All hold/flush outputs are Mealy so the pipe registers react at the same
// edge; a saturating counter records the number of stalled cycles.
module hazard_ctrl #(
    parameter int unsigned MUL_LAT = 4,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       if_id_rs_i,
    input  logic [4:0]       if_id_rt_i,
    input  logic             if_id_uses_rt_i,
    input  logic             id_ex_memread_i,
    input  logic [4:0]       id_ex_rt_i,
    input  logic             mul_start_i,
    input  logic             branch_taken_i,
    output logic             pc_hold_o,
    output logic             IF_Write,
    output logic             IF_flush,
    output logic             id_ex_hold_o,
    output logic             ID_flush,
    output logic             EX_flush,
    output logic             mul_done_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    typedef enum logic [0:0] {
        ST_RUN = 1'b0,
        ST_MUL = 1'b1
    } state_t;

    // Remaining stall cycles after the RUN entry cycle; zero means release.
    localparam logic [7:0]       LP_CNT_LOAD = 8'(MUL_LAT - 2);
    localparam logic [CNT_W-1:0] LP_CNT_MAX  = {CNT_W{1'b1}};

    // A load in ID/EX feeds a source register of the instruction in IF/ID.
    // Register 0 is hardwired to zero and never creates a dependency.
    function automatic logic f_load_use(
        input logic       memread,
        input logic [4:0] ex_rt,
        input logic [4:0] id_rs,
        input logic [4:0] id_rt,
        input logic       uses_rt
    );
        logic match;
        match = (ex_rt == id_rs) || (uses_rt && (ex_rt == id_rt));
        return memread && (ex_rt != 5'd0) && match;
    endfunction

    state_t           r_state;
    state_t           w_next_state;
    logic [7:0]       r_cnt;
    logic [7:0]       w_cnt_next;
    logic [CNT_W-1:0] r_stall_cnt;

    logic w_load_use;
    logic w_pc_hold;
    logic w_if_write;
    logic w_if_flush;
    logic w_id_ex_hold;
    logic w_id_flush;
    logic w_ex_flush;
    logic w_mul_done;

    assign w_load_use = f_load_use(id_ex_memread_i, id_ex_rt_i, if_id_rs_i,
                                   if_id_rt_i, if_id_uses_rt_i);

    // State register and multiply down-counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_RUN;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next-state and counter update; a taken branch squashes a younger multiply.
    always_comb begin
        w_next_state = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            ST_RUN: begin
                if (branch_taken_i) begin
                    w_next_state = ST_RUN;
                end else if (mul_start_i) begin
                    w_next_state = ST_MUL;
                    w_cnt_next   = LP_CNT_LOAD;
                end else begin
                    w_next_state = ST_RUN;
                end
            end
            ST_MUL: begin
                if (r_cnt != 8'd0) begin
                    w_cnt_next = r_cnt - 8'd1;
                end else begin
                    w_next_state = ST_RUN;
                end
            end
            default: begin
                w_next_state = ST_RUN;
                w_cnt_next   = 8'd0;
            end
        endcase
    end

    // Mealy hold/flush decode; reset forces every control low immediately.
    always_comb begin
        w_pc_hold    = 1'b0;
        w_if_write   = 1'b0;
        w_if_flush   = 1'b0;
        w_id_ex_hold = 1'b0;
        w_id_flush   = 1'b0;
        w_ex_flush   = 1'b0;
        w_mul_done   = 1'b0;
        if (rst_i) begin
            w_pc_hold = 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (branch_taken_i) begin
                        w_if_flush = 1'b1;
                        w_id_flush = 1'b1;
                        w_ex_flush = 1'b1;
                    end else if (mul_start_i) begin
                        w_pc_hold    = 1'b1;
                        w_if_write   = 1'b1;
                        w_id_ex_hold = 1'b1;
                        w_ex_flush   = 1'b1;
                    end else if (w_load_use) begin
                        w_pc_hold  = 1'b1;
                        w_if_write = 1'b1;
                        w_id_flush = 1'b1;
                    end else begin
                        w_pc_hold = 1'b0;
                    end
                end
                ST_MUL: begin
                    if (r_cnt != 8'd0) begin
                        w_pc_hold    = 1'b1;
                        w_if_write   = 1'b1;
                        w_id_ex_hold = 1'b1;
                        w_ex_flush   = 1'b1;
                    end else begin
                        w_mul_done = 1'b1;
                    end
                end
                default: begin
                    w_pc_hold = 1'b0;
                end
            endcase
        end
    end

    // Saturating count of stalled cycles, one per edge with IF_Write high.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_stall_cnt <= {CNT_W{1'b0}};
        end else if (w_if_write && (r_stall_cnt != LP_CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end else begin
            r_stall_cnt <= r_stall_cnt;
        end
    end

    assign pc_hold_o    = w_pc_hold;
    assign IF_Write     = w_if_write;
    assign IF_flush     = w_if_flush;
    assign id_ex_hold_o = w_id_ex_hold;
    assign ID_flush     = w_id_flush;
    assign EX_flush     = w_ex_flush;
    assign mul_done_o   = w_mul_done;
    assign stall_cnt_o  = r_stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl: three instances (MUL_LAT=4/CNT_W=16,
// MUL_LAT=2/CNT_W=16, MUL_LAT=4/CNT_W=4) share one stimulus stream and are
// compared against a cycle-age reference model of the hazard rules.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_i;
    logic [4:0] rs, rt, exrt;
    logic       uses_rt, memread, mul_start, branch;

    logic [2:0] pc_hold, if_write, if_flush, id_ex_hold, id_flush, ex_flush, mul_done;
    logic [15:0] cnt_a, cnt_b;
    logic [3:0]  cnt_c;

    logic [6:0]  a_out [3];
    logic [15:0] a_cnt [3];
    logic [6:0]  e_out [3];
    int          e_cnt [3];

    // Model state: m_age = 0 means RUN, otherwise cycles spent in MUL.
    int m_age [3];
    int m_cnt [3] = '{0, 0, 0};
    int lat   [3] = '{4, 2, 4};
    int cmax  [3] = '{65535, 65535, 15};

    int n_checks = 0;
    int n_err    = 0;

    localparam logic [6:0] O_STALL_MUL = 7'b1101010;
    localparam logic [6:0] O_LOAD_USE  = 7'b1100100;
    localparam logic [6:0] O_BRANCH    = 7'b0010110;
    localparam logic [6:0] O_DONE      = 7'b0000001;
    localparam logic [6:0] O_IDLE      = 7'b0000000;

    always #5 clk = ~clk;

    hazard_ctrl #(.MUL_LAT(4), .CNT_W(16)) u_a (
        .clk_i(clk), .rst_i(rst_i), .if_id_rs_i(rs), .if_id_rt_i(rt),
        .if_id_uses_rt_i(uses_rt), .id_ex_memread_i(memread), .id_ex_rt_i(exrt),
        .mul_start_i(mul_start), .branch_taken_i(branch),
        .pc_hold_o(pc_hold[0]), .IF_Write(if_write[0]), .IF_flush(if_flush[0]),
        .id_ex_hold_o(id_ex_hold[0]), .ID_flush(id_flush[0]), .EX_flush(ex_flush[0]),
        .mul_done_o(mul_done[0]), .stall_cnt_o(cnt_a));

    hazard_ctrl #(.MUL_LAT(2), .CNT_W(16)) u_b (
        .clk_i(clk), .rst_i(rst_i), .if_id_rs_i(rs), .if_id_rt_i(rt),
        .if_id_uses_rt_i(uses_rt), .id_ex_memread_i(memread), .id_ex_rt_i(exrt),
        .mul_start_i(mul_start), .branch_taken_i(branch),
        .pc_hold_o(pc_hold[1]), .IF_Write(if_write[1]), .IF_flush(if_flush[1]),
        .id_ex_hold_o(id_ex_hold[1]), .ID_flush(id_flush[1]), .EX_flush(ex_flush[1]),
        .mul_done_o(mul_done[1]), .stall_cnt_o(cnt_b));

    hazard_ctrl #(.MUL_LAT(4), .CNT_W(4)) u_c (
        .clk_i(clk), .rst_i(rst_i), .if_id_rs_i(rs), .if_id_rt_i(rt),
        .if_id_uses_rt_i(uses_rt), .id_ex_memread_i(memread), .id_ex_rt_i(exrt),
        .mul_start_i(mul_start), .branch_taken_i(branch),
        .pc_hold_o(pc_hold[2]), .IF_Write(if_write[2]), .IF_flush(if_flush[2]),
        .id_ex_hold_o(id_ex_hold[2]), .ID_flush(id_flush[2]), .EX_flush(ex_flush[2]),
        .mul_done_o(mul_done[2]), .stall_cnt_o(cnt_c));

    // Pack each instance's outputs as {pc,ifw,iff,idh,idf,exf,done}.
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            a_out[k] = {pc_hold[k], if_write[k], if_flush[k], id_ex_hold[k],
                        id_flush[k], ex_flush[k], mul_done[k]};
        end
        a_cnt[0] = cnt_a;
        a_cnt[1] = cnt_b;
        a_cnt[2] = {12'd0, cnt_c};
    end

    // Expected outputs from the hazard rules for the current model state.
    task automatic predict();
        logic lu;
        lu = memread && (exrt != 5'd0) && ((exrt == rs) || (uses_rt && (exrt == rt)));
        for (int k = 0; k < 3; k++) begin
            e_out[k] = O_IDLE;
            if (!rst_i) begin
                if (m_age[k] > 0)       e_out[k] = (m_age[k] < lat[k] - 1) ? O_STALL_MUL : O_DONE;
                else if (branch)        e_out[k] = O_BRANCH;
                else if (mul_start)     e_out[k] = O_STALL_MUL;
                else if (lu)            e_out[k] = O_LOAD_USE;
            end
            e_cnt[k] = m_cnt[k];
        end
    endtask

    task automatic drive(input logic r, input logic [4:0] a_rs, input logic [4:0] a_rt,
                         input logic a_use, input logic a_mr, input logic [4:0] a_exrt,
                         input logic a_mul, input logic a_br);
        rst_i = r; rs = a_rs; rt = a_rt; uses_rt = a_use;
        memread = a_mr; exrt = a_exrt; mul_start = a_mul; branch = a_br;
        #1;
        predict();
    endtask

    // Advance one clock and update the model with this cycle's decisions.
    task automatic tick();
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            if (rst_i) begin
                m_age[k] = 0;
                m_cnt[k] = 0;
            end else begin
                if (e_out[k][5] && m_cnt[k] < cmax[k]) m_cnt[k] = m_cnt[k] + 1;
                if (m_age[k] == 0) begin
                    if (!branch && mul_start) m_age[k] = 1;
                end else if (m_age[k] == lat[k] - 1) begin
                    m_age[k] = 0;
                end else begin
                    m_age[k] = m_age[k] + 1;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        drive(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (a_out[k] !== O_IDLE) begin
                n_err++;
                $display("FAIL reset_outputs inst%0d: got %b, expected %b", k, a_out[k], O_IDLE);
            end
        end
        tick();
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (a_out[k] !== e_out[k] || a_cnt[k] !== 16'(e_cnt[k])) begin
                n_err++;
                $display("FAIL reset_state inst%0d: got %b/%0d, expected %b/%0d",
                         k, a_out[k], a_cnt[k], e_out[k], e_cnt[k]);
            end
        end
    endtask

    task automatic test_load_use();
        logic [5:0] pat [5];
        pat[0] = {1'b1, 1'b0, 1'b0, 3'd0}; // rs match
        pat[1] = {1'b0, 1'b1, 1'b1, 3'd0}; // rt match, rt used
        pat[2] = {1'b0, 1'b1, 1'b0, 3'd0}; // rt match, rt unused: no stall
        pat[3] = {1'b1, 1'b0, 1'b0, 3'd1}; // load to r0: no stall
        pat[4] = {1'b0, 1'b0, 1'b0, 3'd0}; // no match
        drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        tick();
        for (int p = 0; p < 5; p++) begin
            logic [4:0] dst;
            dst = pat[p][0] ? 5'd0 : 5'd5;
            drive(1'b0, pat[p][5] ? dst : 5'd9, pat[p][4] ? dst : 5'd10,
                  pat[p][3], 1'b1, dst, 1'b0, 1'b0);
            for (int k = 0; k < 3; k++) begin
                n_checks++;
                if (a_out[k] !== e_out[k] || a_cnt[k] !== 16'(e_cnt[k])) begin
                    n_err++;
                    $display("FAIL load_use p%0d inst%0d: got %b/%0d, expected %b/%0d",
                             p, k, a_out[k], a_cnt[k], e_out[k], e_cnt[k]);
                end
            end
            tick();
        end
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        n_checks++;
        if (a_cnt[0] !== 16'd2 || a_out[0] !== O_IDLE) begin
            n_err++;
            $display("FAIL load_use_count: got %0d/%b, expected 2/%b", a_cnt[0], a_out[0], O_IDLE);
        end
    endtask

    task automatic test_multiply();
        int dn;
        dn = 0;
        drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        tick();
        for (int c = 0; c < 8; c++) begin
            drive(1'b0, 5'd1, 5'd2, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0);
            for (int k = 0; k < 3; k++) begin
                n_checks++;
                if (a_out[k] !== e_out[k] || a_cnt[k] !== 16'(e_cnt[k])) begin
                    n_err++;
                    $display("FAIL multiply c%0d inst%0d: got %b/%0d, expected %b/%0d",
                             c, k, a_out[k], a_cnt[k], e_out[k], e_cnt[k]);
                end
            end
            if (mul_done[0]) dn++;
            tick();
        end
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        n_checks++;
        if (dn != 2 || a_cnt[0] !== 16'd6 || a_cnt[1] !== 16'd4) begin
            n_err++;
            $display("FAIL back_to_back: got done=%0d cntA=%0d cntB=%0d, expected 2/6/4",
                     dn, a_cnt[0], a_cnt[1]);
        end
    endtask

    task automatic test_mul_lat2();
        drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
        n_checks++;
        if (a_out[1] !== O_STALL_MUL) begin
            n_err++;
            $display("FAIL lat2_stall: got %b, expected %b", a_out[1], O_STALL_MUL);
        end
        tick();
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        n_checks++;
        if (a_out[1] !== O_DONE || a_cnt[1] !== 16'd1) begin
            n_err++;
            $display("FAIL lat2_release: got %b/%0d, expected %b/1", a_out[1], a_cnt[1], O_DONE);
        end
        tick();
    endtask

    task automatic test_branch_priority();
        drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (a_out[k] !== O_BRANCH) begin
                n_err++;
                $display("FAIL branch_prio inst%0d: got %b, expected %b", k, a_out[k], O_BRANCH);
            end
        end
        tick();
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (a_out[k] !== O_IDLE || a_cnt[k] !== 16'd0) begin
                n_err++;
                $display("FAIL branch_after inst%0d: got %b/%0d, expected %b/0",
                         k, a_out[k], a_cnt[k], O_IDLE);
            end
        end
    endtask

    task automatic test_reset_mid_mul();
        drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
        n_checks++;
        if (a_out[0] !== O_IDLE) begin
            n_err++;
            $display("FAIL mid_mul_reset: got %b, expected %b", a_out[0], O_IDLE);
        end
        tick();
        for (int c = 0; c < 4; c++) begin
            drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, (c < 3) ? 1'b1 : 1'b0, 1'b0);
            for (int k = 0; k < 3; k++) begin
                n_checks++;
                if (a_out[k] !== e_out[k] || a_cnt[k] !== 16'(e_cnt[k])) begin
                    n_err++;
                    $display("FAIL mid_mul_restart c%0d inst%0d: got %b/%0d, expected %b/%0d",
                             c, k, a_out[k], a_cnt[k], e_out[k], e_cnt[k]);
                end
            end
            tick();
        end
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        n_checks++;
        if (a_cnt[0] !== 16'd3) begin
            n_err++;
            $display("FAIL mid_mul_count: got %0d, expected 3", a_cnt[0]);
        end
    endtask

    task automatic test_saturation();
        drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        tick();
        for (int c = 0; c < 20; c++) begin
            drive(1'b0, 5'd7, 5'd0, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        n_checks++;
        if (a_cnt[2] !== 16'd15 || a_cnt[0] !== 16'd20) begin
            n_err++;
            $display("FAIL saturation: got small=%0d wide=%0d, expected 15/20", a_cnt[2], a_cnt[0]);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            drive(($urandom_range(0, 39) == 0), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  1'($urandom), 1'($urandom), 5'($urandom_range(0, 7)),
                  ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0));
            for (int k = 0; k < 3; k++) begin
                n_checks++;
                if (a_out[k] !== e_out[k] || a_cnt[k] !== 16'(e_cnt[k])
                    || (if_write[k] && if_flush[k]) || (id_ex_hold[k] && id_flush[k])
                    || (pc_hold[k] !== if_write[k])) begin
                    n_err++;
                    $display("FAIL random c%0d inst%0d: got %b/%0d, expected %b/%0d",
                             c, k, a_out[k], a_cnt[k], e_out[k], e_cnt[k]);
                end
            end
            tick();
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) m_age[k] = 0;
        #1;
        test_reset();
        test_load_use();
        test_multiply();
        test_mul_lat2();
        test_branch_priority();
        test_reset_mid_mul();
        test_saturation();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
